controller: RTL

Instruction sequencer for the 8-bit accumulator CPU, directly upstream of the ALU. It steps every instruction through a fixed eight-phase cycle. Each phase is one clock. It issues the memory, instruction-register, program-counter and accumulator control strobes that frame each ALU operation. Its inputs are the decoded instruction opcode and the ALU `zero` flag, which it uses for conditional skip.

---
 rtl/typedefs_pkg.sv | 27 ++
 rtl/controller.sv | 106 ++++++++++
 2 files changed

// File: rtl/typedefs_pkg.sv
// rtl/typedefs_pkg.sv - shared CPU typedefs: opcode encoding and controller states
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } ctrl_state_t;

endpackage

// File: rtl/controller.sv
// rtl/controller.sv - eight-phase instruction sequencer; CTRL_HALT_RESUME_EN adds go to leave HALTED
module controller
  import typedefs::*;
(
  input  logic    clk,
  input  logic    rst,
  input  opcode_t opcode,
  input  logic    zero,
`ifdef CTRL_HALT_RESUME_EN
  input  logic    go,
`endif
  output logic    mem_rd,
  output logic    mem_wr,
  output logic    load_ir,
  output logic    inc_pc,
  output logic    load_pc,
  output logic    load_ac,
  output logic    halt
);

  ctrl_state_t state_q, state_d;
  logic aluop, is_hlt, is_skz, is_jmp, is_sto;

  always_ff @(posedge clk) begin
    if (rst) state_q <= INST_ADDR;
    else     state_q <= state_d;
  end

  // Opcode decode; anything not matched (including illegal values) is treated as a no-op.
  always_comb begin
    aluop  = 1'b0;
    is_hlt = 1'b0;
    is_skz = 1'b0;
    is_jmp = 1'b0;
    is_sto = 1'b0;
    case (opcode)
      ADD, AND, XOR, LDA: aluop  = 1'b1;
      HLT:                is_hlt = 1'b1;
      SKZ:                is_skz = 1'b1;
      JMP:                is_jmp = 1'b1;
      STO:                is_sto = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ac = 1'b0;
    halt    = 1'b0;
    case (state_q)
      INST_ADDR: state_d = INST_FETCH;
      INST_FETCH: begin
        state_d = INST_LOAD;
        mem_rd  = 1'b1;
      end
      INST_LOAD: begin
        state_d = IDLE;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      IDLE: begin
        state_d = OP_ADDR;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        state_d = is_hlt ? HALTED : OP_FETCH;
        inc_pc  = 1'b1;
        halt    = is_hlt;
      end
      OP_FETCH: begin
        state_d = ALU_OP;
        mem_rd  = aluop;
      end
      // zero only matters here, where SKZ decides whether to skip the next word.
      ALU_OP: begin
        state_d = STORE;
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = is_skz & zero;
        load_pc = is_jmp;
      end
      STORE: begin
        state_d = INST_ADDR;
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = is_jmp;
        load_pc = is_jmp;
        mem_wr  = is_sto;
      end
      HALTED: begin
        halt = 1'b1;
`ifdef CTRL_HALT_RESUME_EN
        if (go) state_d = INST_ADDR;
`endif
      end
      default: state_d = INST_ADDR;
    endcase
  end

endmodule
